// File: rtl/n_1_mux_pkg.sv
// Shared constants and helpers for the N:1 bit-select multiplexer.
package n_1_mux_pkg;

  localparam int N_DEFAULT = 16;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/n_1_mux_if.sv
// Data/select inputs and mux outputs bundled for the N:1 bit-select multiplexer.
interface n_1_mux_if
  import n_1_mux_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int SEL_W = sel_width(N)
);

  logic [N-1:0]     in;
  logic [SEL_W-1:0] sel;
  logic             y;
  logic             y_q;
  logic             sel_oor;

  modport master (output in, sel, input y, y_q, sel_oor);
  modport slave  (input in, sel, output y, y_q, sel_oor);

endinterface

// File: rtl/n_1_mux_stage.sv
// One 2:1 level of the select tree: pairs adjacent bits of a vector under one select bit.
module n_1_mux_stage #(
  parameter int W = 2
) (
  input  logic [W-1:0]   in_i,
  input  logic           s_i,
  output logic [W/2-1:0] out_o
);

  always_comb begin
    out_o = '0;
    for (int j = 0; j < W / 2; j++) begin
      out_o[j] = s_i ? in_i[2*j+1] : in_i[2*j];
    end
  end

endmodule

// File: rtl/n_1_mux.sv
// N:1 single-bit multiplexer built as a binary tree of 2:1 levels, with a registered copy of y.
module n_1_mux
  import n_1_mux_pkg::*;
#(
  parameter int   N     = N_DEFAULT,
  parameter int   SEL_W = sel_width(N),
  parameter logic OOR_Y = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  n_1_mux_if.slave   bus
);

  localparam int P = 2 ** SEL_W;

  logic [P-1:0] padded;
  logic         y_d;
  logic         y_reg_q;

  // Positions beyond N carry OOR_Y, so an out-of-range select falls through the tree to it.
  if (P > N) begin : g_pad
    assign padded = {{(P - N){OOR_Y}}, bus.in};
  end else begin : g_nopad
    assign padded = bus.in;
  end

  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    localparam int W = 2 ** (SEL_W - l);
    logic [W-1:0]   vin;
    logic [W/2-1:0] vout;

    if (l == 0) begin : g_first
      assign vin = padded;
    end else begin : g_next
      assign vin = g_lvl[l-1].vout;
    end

    n_1_mux_stage #(.W(W)) u_stage (
      .in_i  (vin),
      .s_i   (bus.sel[l]),
      .out_o (vout)
    );
  end

  assign y_d         = g_lvl[SEL_W-1].vout[0];
  assign bus.y       = y_d;
  assign bus.sel_oor = (int'(bus.sel) >= N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg_q <= 1'b0;
    end else begin
      y_reg_q <= y_d;
    end
  end

  assign bus.y_q = y_reg_q;

endmodule

// File: tb/tb_n_1_mux.sv
// Self-checking bench for n_1_mux: 16:1 and 10:1 instances, scoreboard of expected outputs.
module tb_n_1_mux;

  typedef struct {
    logic  exp_y;
    logic  exp_oor;
    string tag;
  } sb_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  sb_t  sb_q[$];

  n_1_mux_if #(.N(16), .SEL_W(4)) bus16 ();
  n_1_mux_if #(.N(10), .SEL_W(4)) bus10 ();

  n_1_mux #(.N(16), .SEL_W(4), .OOR_Y(1'b0)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  n_1_mux #(.N(10), .SEL_W(4), .OOR_Y(1'b0)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    sb_t e;
    rst = 1'b1;
    bus16.in = 16'h0000; bus16.sel = 4'd0;
    bus10.in = 10'h000;  bus10.sel = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus16.y_q !== 1'b0) begin
      errors++; $display("FAIL reset_y_q16: got %b want 0", bus16.y_q);
    end
    checks++;
    if (bus10.y_q !== 1'b0) begin
      errors++; $display("FAIL reset_y_q10: got %b want 0", bus10.y_q);
    end
    // reset must dominate clock edges even while y is high
    @(negedge clk);
    bus16.in = 16'hFFFF; bus16.sel = 4'd5;
    e.exp_y = 1'b1; e.exp_oor = 1'b0; e.tag = "reset_y_comb";
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus16.y !== e.exp_y) begin
      errors++; $display("FAIL %s: got %b want %b", e.tag, bus16.y, e.exp_y);
    end
    checks++;
    if (bus16.y_q !== 1'b0) begin
      errors++; $display("FAIL reset_hold_y_q: got %b want 0", bus16.y_q);
    end
  endtask

  task automatic test_patterns();
    logic [15:0] pin [7];
    logic [3:0]  psel[7];
    logic        pexp[7];
    sb_t e;
    pin[0] = 16'b1000000000000000; psel[0] = 4'd0;  pexp[0] = 1'b0;
    pin[1] = 16'b0100000000000010; psel[1] = 4'd1;  pexp[1] = 1'b1;
    pin[2] = 16'b0000100000011000; psel[2] = 4'd4;  pexp[2] = 1'b1;
    pin[3] = 16'b0000000111100000; psel[3] = 4'd7;  pexp[3] = 1'b1;
    pin[4] = 16'b0000011000100000; psel[4] = 4'd10; pexp[4] = 1'b1;
    pin[5] = 16'b1000000000000001; psel[5] = 4'd15; pexp[5] = 1'b1;
    pin[6] = 16'b0001000000000000; psel[6] = 4'd3;  pexp[6] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus16.in = pin[i]; bus16.sel = psel[i];
      e.exp_y = pexp[i]; e.exp_oor = 1'b0; e.tag = $sformatf("pattern%0d", i);
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (bus16.y !== e.exp_y || bus16.sel_oor !== e.exp_oor) begin
        errors++;
        $display("FAIL %s: got y=%b oor=%b want y=%b oor=%b",
                 e.tag, bus16.y, bus16.sel_oor, e.exp_y, e.exp_oor);
      end
    end
  endtask

  task automatic test_exhaustive();
    sb_t e;
    logic [15:0] oh;
    for (int k = 0; k < 16; k++) begin
      oh = 16'h0001 << k;
      for (int s = 0; s < 16; s++) begin
        bus16.in = oh; bus16.sel = 4'(s);
        e.exp_y = (s == k); e.exp_oor = 1'b0; e.tag = $sformatf("onehot_k%0d_s%0d", k, s);
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (bus16.y !== e.exp_y || bus16.sel_oor !== e.exp_oor) begin
          errors++;
          $display("FAIL %s: got y=%b oor=%b want y=%b oor=%b",
                   e.tag, bus16.y, bus16.sel_oor, e.exp_y, e.exp_oor);
        end
      end
    end
  endtask

  task automatic test_registered();
    sb_t e;
    @(negedge clk);
    bus16.in = 16'h0000; bus16.sel = 4'd5;
    rst = 1'b1;
    #1;
    checks++;
    if (bus16.y_q !== 1'b0) begin
      errors++; $display("FAIL reg_rst: got %b want 0", bus16.y_q);
    end
    rst = 1'b0;
    bus16.in = 16'hFFFF; bus16.sel = 4'd5;
    e.exp_y = 1'b1; e.exp_oor = 1'b0; e.tag = "reg_first_edge";
    sb_q.push_back(e);
    #1;
    checks++;
    if (bus16.y_q !== 1'b0) begin
      errors++; $display("FAIL reg_before_edge: got %b want 0", bus16.y_q);
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus16.y_q !== e.exp_y) begin
      errors++; $display("FAIL %s: got %b want %b", e.tag, bus16.y_q, e.exp_y);
    end
  endtask

  task automatic test_async_reset();
    sb_t e;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus16.y_q !== 1'b0) begin
      errors++; $display("FAIL async_clear: got %b want 0", bus16.y_q);
    end
    checks++;
    if (bus16.y !== 1'b1) begin
      errors++; $display("FAIL async_y_tracks: got %b want 1", bus16.y);
    end
    #1;
    rst = 1'b0;
    e.exp_y = 1'b1; e.exp_oor = 1'b0; e.tag = "async_recover";
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (bus16.y_q !== e.exp_y) begin
      errors++; $display("FAIL %s: got %b want %b", e.tag, bus16.y_q, e.exp_y);
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    logic [15:0] v;
    logic [3:0]  s;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      v = 16'($urandom);
      s = 4'($urandom_range(0, 15));
      bus16.in = v; bus16.sel = s;
      e.exp_y = v[s]; e.exp_oor = 1'b0; e.tag = $sformatf("b2b_%0d", i);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (bus16.y_q !== e.exp_y) begin
        errors++; $display("FAIL %s: got y_q=%b want %b (in=%h sel=%0d)", e.tag, bus16.y_q, e.exp_y, v, s);
      end
    end
  endtask

  task automatic test_non_pow2();
    sb_t e;
    logic [9:0] v;
    bus10.in = 10'h3FF;
    for (int s = 0; s < 16; s++) begin
      bus10.sel = 4'(s);
      e.exp_y = (s < 10); e.exp_oor = (s >= 10); e.tag = $sformatf("n10_all1_s%0d", s);
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (bus10.y !== e.exp_y || bus10.sel_oor !== e.exp_oor) begin
        errors++;
        $display("FAIL %s: got y=%b oor=%b want y=%b oor=%b",
                 e.tag, bus10.y, bus10.sel_oor, e.exp_y, e.exp_oor);
      end
    end
    for (int k = 0; k < 10; k++) begin
      v = 10'h001 << k;
      bus10.in = v; bus10.sel = 4'(k);
      e.exp_y = 1'b1; e.exp_oor = 1'b0; e.tag = $sformatf("n10_onehot_%0d", k);
      sb_q.push_back(e);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (bus10.y !== e.exp_y || bus10.sel_oor !== e.exp_oor) begin
        errors++;
        $display("FAIL %s: got y=%b oor=%b want y=%b oor=%b",
                 e.tag, bus10.y, bus10.sel_oor, e.exp_y, e.exp_oor);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    test_reset();
    test_patterns();
    test_exhaustive();
    test_registered();
    test_async_reset();
    test_back_to_back();
    test_non_pow2();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
